led_fill_seq: RTL and testbench
===============================

# led_fill_seq

Sequencer for the 16-LED fill/drain display path. A push-button starts a cycle that fills the LED bar one position per step from bit 0 upward, holds it full, then drains it back to zero. The block owns the step prescaler, the button synchronizer and edge detect, and the run/pause state machine. It sits between board-level inputs (button, rate switches) and the LED pins.

## Interface
- TICK_DIV, 4: base step period in clk cycles; must be ≥ 1.
- HOLD_STEPS, 4: steps spent in HOLD with all LEDs lit; must be ≥ 1.
- clk  in  1  single system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- button  in  1  raw asynchronous push-button, active high.
- switch  in  3  rate select; step period = TICK_DIV << switch cycles.
- led  out  16  LED bar pattern.
- busy  out  1  high in FILL, HOLD, DRAIN and PAUSE.
- done  out  1  one-cycle pulse on the DRAIN→IDLE transition.

## Operation
- Button path: 2-FF synchronizer, then a rising-edge detect on the synced level, giving `press` as a 1-cycle pulse. Level-high holds give exactly one press.
- States: IDLE, FILL, HOLD, DRAIN, PAUSE. PAUSE stores the state to resume.
- IDLE: led=0. On `press`: latch switch into rate_q, clear the prescaler and the step counter, go to FILL.
- FILL: on each tick, led <= {led[14:0],1'b1}. After the 16th tick, led=16'hFFFF; go to HOLD with the step counter cleared.
- HOLD: led held at 16'hFFFF. After HOLD_STEPS ticks, go to DRAIN.
- DRAIN: on each tick, led <= {1'b0,led[15:1]}. The tick that makes led=0 moves the FSM to IDLE and pulses done.
- `press` in FILL, HOLD or DRAIN enters PAUSE. While paused, led, the prescaler and the step counter are frozen.
- `press` in PAUSE returns to the saved state. The prescaler continues from its frozen value.
- Press and tick in the same cycle: the press wins, and the tick is discarded.
- Prescaler: counts 0 … (TICK_DIV<<rate_q)−1. tick = (count == max) while running. Width is $clog2(TICK_DIV<<7).
- A switch change while busy has no effect until the next start.

## Timing
- Reset (async assert, state cleared immediately): state=IDLE, led=16'h0000, busy=0, done=0, prescaler=0, sync flops=0.
- Reset deassertion is sampled synchronously; the first active edge follows the deassertion.
- Button latency: button rises before edge k. Sync flops capture it at k and k+1, press is high during cycle k+1→k+2, and the state updates at edge k+2.
- The first FILL tick occurs P cycles after entering FILL, where P = TICK_DIV<<rate_q.
- Full cycle from start to done: (16 + HOLD_STEPS + 16)·P cycles, excluding PAUSE time.
- done rises on the same edge as led becoming 0 and the FSM entering IDLE. busy falls on that same edge.
- Outputs are registered; there is no combinational path from button or switch to the outputs.
- Reset in mid-operation aborts to IDLE with led=0; no done pulse is generated.

## Configuration
- LED_FILL_SEQ_LOOP_EN defined: DRAIN completion still pulses done, but goes directly to FILL with rate_q re-latched from switch. busy stays high, and only a press (pause) or reset stops the sequence.
- LED_FILL_SEQ_LOOP_EN undefined: DRAIN completion goes to IDLE, as described in Operation.

## Structure
- Package led_fill_pkg holds:
  - the state enum typedef (IDLE, FILL, HOLD, DRAIN, PAUSE);
  - LED_W = 16;
  - the rate-select width of 3;
  - the prescaler width function.
- Sub-module led_tick_gen: the prescaler, with ports clk, rst_n, clr, en, rate[2:0] and tick. clr resets the count; en=0 freezes it.
- The button synchronizer and edge detect stay inline in led_fill_seq.

## Test plan
- Reset and idle: rst_n low for 3 cycles, then high, no button → led=0, busy=0, done=0 for 200 cycles.
- Basic cycle (TICK_DIV=2, HOLD_STEPS=4, switch=0): one press →
  - led steps through 0x0001, 0x0003, … 0xFFFF every 2 cycles;
  - holds 0xFFFF for 8 cycles;
  - drains 0x7FFF … 0x0000;
  - done pulses once; total 72 cycles from the FILL entry.
- Rate select: switch=2 latched at start, then changed to 0 mid-FILL → step period stays 8 cycles for the whole cycle.
- Pause/resume: press at led=0x00FF, hold 50 cycles, press again → led stays 0x00FF while paused, then continues to 0x01FF; total active time is unchanged.
- Button held high for 100 cycles in IDLE → exactly one start, with no pause.
- Async reset mid-DRAIN at led=0x0FFF → led=0 immediately, IDLE, no done pulse.
- Loop build: with LED_FILL_SEQ_LOOP_EN defined → done pulses after each drain, led restarts at 0x0001 one step later, and busy stays 1.

Source files
------------

// File: rtl/led_fill_pkg.sv
// ============================================================================
//  Module      : led_fill_pkg
//  Description : Shared types and constants for the LED fill/drain sequencer:
//                FSM state encoding, LED bar width, rate-select width and the
//                prescaler width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_fill_pkg;

    // Sequencer states; PAUSE remembers which of FILL/HOLD/DRAIN to resume
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    localparam int LED_W  = 16;
    localparam int RATE_W = 3;

    // Prescaler width large enough for the slowest rate (rate = 7)
    function automatic int presc_width(input int tick_div);
        return $clog2(tick_div << 7);
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// ============================================================================
//  Module      : led_tick_gen
//  Description : Step prescaler. Counts 0 .. (TICK_DIV << rate) - 1 while
//                enabled and raises tick for the cycle the count sits at its
//                maximum. clr restarts the count; en = 0 freezes it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_tick_gen
    import led_fill_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [RATE_W-1:0] rate,
    output logic              tick
);

    localparam int CNT_W = presc_width(TICK_DIV);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_max;

    // When the period equals 2**CNT_W the shift wraps to zero and the
    // subtraction wraps back to all-ones, which is still the right maximum.
    assign w_max = (CNT_W'(TICK_DIV) << rate) - CNT_W'(1);
    assign tick  = en & (r_count == w_max);

    // Free-running modulo-period counter with clear priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            if (r_count == w_max) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_fill_seq.sv
// ============================================================================
//  Module      : led_fill_seq
//  Description : 16-LED fill/hold/drain sequencer with push-button start and
//                pause/resume, button synchronizer and edge detect, and a
//                switch-selected step rate latched at each start.
//                Optional build macro LED_FILL_SEQ_LOOP_EN: on DRAIN
//                completion restart FILL (re-latching the rate) instead of
//                returning to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_fill_seq
    import led_fill_pkg::*;
#(
    parameter int TICK_DIV   = 4,
    parameter int HOLD_STEPS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              button,
    input  logic [RATE_W-1:0] switch,
    output logic [LED_W-1:0]  led,
    output logic              busy,
    output logic              done
);

    localparam int STEP_MAX = (HOLD_STEPS > LED_W) ? HOLD_STEPS : LED_W;
    localparam int STEP_W   = $clog2(STEP_MAX);
    localparam logic [STEP_W-1:0] C_FILL_LAST = STEP_W'(LED_W - 1);
    localparam logic [STEP_W-1:0] C_HOLD_LAST = STEP_W'(HOLD_STEPS - 1);

    logic              r_sync0, r_sync1, r_sync_d;
    logic              w_press;
    state_t            r_state,  w_state_nx;
    state_t            r_resume, w_resume_nx;
    logic [LED_W-1:0]  r_led,    w_led_nx;
    logic [STEP_W-1:0] r_step,   w_step_nx;
    logic [RATE_W-1:0] r_rate,   w_rate_nx;
    logic              r_done,   w_done_nx;
    logic              w_run, w_en, w_clr, w_tick;

    // Two-flop synchronizer plus a delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync0  <= button;
            r_sync1  <= r_sync0;
            r_sync_d <= r_sync1;
        end
    end

    assign w_press = r_sync1 & ~r_sync_d;
    assign w_run   = (r_state == S_FILL) || (r_state == S_HOLD) || (r_state == S_DRAIN);
    // The press cycle does not advance the prescaler, so a coincident tick
    // is not lost: it fires again on the first cycle after resume.
    assign w_en    = w_run & ~w_press;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .en    (w_en),
        .rate  (r_rate),
        .tick  (w_tick)
    );

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_resume <= S_IDLE;
            r_led    <= '0;
            r_step   <= '0;
            r_rate   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_resume <= w_resume_nx;
            r_led    <= w_led_nx;
            r_step   <= w_step_nx;
            r_rate   <= w_rate_nx;
            r_done   <= w_done_nx;
        end
    end

    // Next-state, LED pattern, step counter and prescaler control
    always_comb begin
        w_state_nx  = r_state;
        w_resume_nx = r_resume;
        w_led_nx    = r_led;
        w_step_nx   = r_step;
        w_rate_nx   = r_rate;
        w_done_nx   = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_led_nx = '0;
                if (w_press) begin
                    w_rate_nx  = switch;
                    w_clr      = 1'b1;
                    w_step_nx  = '0;
                    w_state_nx = S_FILL;
                end
            end
            S_FILL, S_HOLD, S_DRAIN: begin
                if (w_press) begin
                    w_resume_nx = r_state;
                    w_state_nx  = S_PAUSE;
                end else if (w_tick) begin
                    if (r_state == S_FILL) begin
                        w_led_nx = {r_led[LED_W-2:0], 1'b1};
                        if (r_step == C_FILL_LAST) begin
                            w_step_nx  = '0;
                            w_state_nx = S_HOLD;
                        end else begin
                            w_step_nx = r_step + STEP_W'(1);
                        end
                    end else if (r_state == S_HOLD) begin
                        if (r_step == C_HOLD_LAST) begin
                            w_step_nx  = '0;
                            w_state_nx = S_DRAIN;
                        end else begin
                            w_step_nx = r_step + STEP_W'(1);
                        end
                    end else begin
                        w_led_nx = {1'b0, r_led[LED_W-1:1]};
                        if (r_led[LED_W-1:1] == '0) begin
                            w_done_nx = 1'b1;
`ifdef LED_FILL_SEQ_LOOP_EN
                            w_rate_nx  = switch;
                            w_clr      = 1'b1;
                            w_step_nx  = '0;
                            w_state_nx = S_FILL;
`else
                            w_state_nx = S_IDLE;
`endif
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (w_press) begin
                    w_state_nx = r_resume;
                end
            end
            default: begin
                w_led_nx   = '0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign led  = r_led;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_led_fill_seq.sv
// ============================================================================
//  Module      : tb_led_fill_seq
//  Description : Self-checking bench for led_fill_seq: vector table for the
//                basic cycle, hand-written corner sequences and a random
//                phase compared against a step-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_fill_seq;

    localparam int TICK_DIV   = 2;
    localparam int HOLD_STEPS = 4;
    localparam int ALL_STEPS  = 32 + HOLD_STEPS;
`ifdef LED_FILL_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        button = 1'b0;
    logic [2:0]  switch = 3'd0;
    logic [15:0] led;
    logic        busy;
    logic        done;

    led_fill_seq #(
        .TICK_DIV   (TICK_DIV),
        .HOLD_STEPS (HOLD_STEPS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .button (button),
        .switch (switch),
        .led    (led),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_seen = 0;
    bit mdl_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The sequence is a count of active (running, non-press) cycles; the LED
    // pattern follows from how many whole step periods that count covers.
    function automatic logic [15:0] led_of(input int n);
        if (n <= 16)
            return 16'((32'd1 << n) - 32'd1);
        else if (n <= 16 + HOLD_STEPS)
            return 16'hFFFF;
        else
            return 16'(32'h0000FFFF >> (n - 16 - HOLD_STEPS));
    endfunction

    logic [15:0] m_led = '0;
    bit m_busy = 0, m_paused = 0, m_done = 0, m_press = 0;
    int m_act = 0, m_P = 1;
    bit b_hist [0:2] = '{0, 0, 0};

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_paused = 0; m_done = 0; m_act = 0; m_led = '0;
                b_hist = '{0, 0, 0};
            end else begin
                m_press   = b_hist[1] && !b_hist[2];
                b_hist[2] = b_hist[1];
                b_hist[1] = b_hist[0];
                b_hist[0] = button;
                m_done = 0;
                if (!m_busy) begin
                    if (m_press) begin
                        m_busy = 1; m_paused = 0; m_act = 0;
                        m_P = TICK_DIV << switch;
                    end
                end else if (m_paused) begin
                    if (m_press) m_paused = 0;
                end else if (m_press) begin
                    m_paused = 1;
                end else begin
                    m_act++;
                    if ((m_act % m_P == 0) && (m_act / m_P == ALL_STEPS)) begin
                        m_done = 1;
                        if (LOOP) begin
                            m_act = 0;
                            m_P = TICK_DIV << switch;
                        end else begin
                            m_busy = 0;
                        end
                    end
                end
                m_led = m_busy ? led_of(m_act / m_P) : 16'h0000;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mdl_en) begin
                chk("model_led", led, m_led);
                chk("model_busy", busy, m_busy);
                chk("model_done", done, m_done);
                if (done) done_seen++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed helpers ----------------
    task automatic step_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        button = 1'b0;
        #1;
        chk("reset_led", led, 16'h0000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mdl_en = 1'b1;
    endtask

    // Leaves cyc = 0 at the first negedge after the FILL entry edge
    task automatic start_run(input logic [2:0] sw, input bit release_btn);
        switch = sw;
        button = 1'b1;
        repeat (2) @(negedge clk);
        chk("start_latency_busy_low", busy, 1'b0);
        @(negedge clk);
        chk("start_busy_high", busy, 1'b1);
        cyc = 0;
        done_seen = 0;
        if (release_btn) button = 1'b0;
    endtask

    typedef struct {
        int          cyc;
        logic [15:0] led;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [0:14];
    int   bad;

    initial begin
        tbl[0]  = '{0,  16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{1,  16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{2,  16'h0001, 1'b1, 1'b0};
        tbl[3]  = '{3,  16'h0001, 1'b1, 1'b0};
        tbl[4]  = '{4,  16'h0003, 1'b1, 1'b0};
        tbl[5]  = '{16, 16'h00FF, 1'b1, 1'b0};
        tbl[6]  = '{31, 16'h7FFF, 1'b1, 1'b0};
        tbl[7]  = '{32, 16'hFFFF, 1'b1, 1'b0};
        tbl[8]  = '{41, 16'hFFFF, 1'b1, 1'b0};
        tbl[9]  = '{42, 16'h7FFF, 1'b1, 1'b0};
        tbl[10] = '{44, 16'h3FFF, 1'b1, 1'b0};
        tbl[11] = '{71, 16'h0001, 1'b1, 1'b0};
        tbl[12] = '{72, 16'h0000, LOOP, 1'b1};
        tbl[13] = '{73, 16'h0000, LOOP, 1'b0};
        tbl[14] = '{74, LOOP ? 16'h0001 : 16'h0000, LOOP, 1'b0};

        #3;

        // Reset and idle
        do_reset();
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (led !== 16'h0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle_bad_cycles", bad, 0);

        // Basic cycle from the vector table
        start_run(3'd0, 1'b1);
        for (int i = 0; i <= 14; i++) begin
            step_to(tbl[i].cyc);
            chk($sformatf("basic_led_c%0d", tbl[i].cyc), led, tbl[i].led);
            chk($sformatf("basic_busy_c%0d", tbl[i].cyc), busy, tbl[i].busy);
            chk($sformatf("basic_done_c%0d", tbl[i].cyc), done, tbl[i].done);
        end

        // Rate latched at start; mid-run switch change ignored
        do_reset();
        start_run(3'd2, 1'b1);
        step_to(8);   chk("rate_led_c8", led, 16'h0001);
        step_to(10);  switch = 3'd0;
        step_to(15);  chk("rate_led_c15", led, 16'h0001);
        step_to(16);  chk("rate_led_c16", led, 16'h0003);
        step_to(127); chk("rate_led_c127", led, 16'h7FFF);
        step_to(128); chk("rate_led_c128", led, 16'hFFFF);
        step_to(287); chk("rate_done_c287", done, 1'b0);
        step_to(288); chk("rate_done_c288", done, 1'b1);
                      chk("rate_led_c288", led, 16'h0000);
                      chk("rate_busy_c288", busy, LOOP);

        // Pause at 0x00FF, hold the button, resume
        do_reset();
        start_run(3'd0, 1'b1);
        step_to(14);
        button = 1'b1;
        step_to(18);
        chk("pause_led_entry", led, 16'h00FF);
        bad = 0;
        while (cyc < 70) begin
            @(negedge clk);
            cyc++;
            if (cyc == 64) button = 1'b0;
            if (led !== 16'h00FF || busy !== 1'b1) bad++;
        end
        chk("pause_frozen_bad_cycles", bad, 0);
        button = 1'b1;
        step_to(71);  button = 1'b0;
        step_to(74);  chk("resume_led_c74", led, 16'h00FF);
        step_to(75);  chk("resume_led_c75", led, 16'h01FF);
        step_to(128); chk("resume_done_c128", done, 1'b0);
                      chk("resume_led_c128", led, 16'h0001);
        step_to(129); chk("resume_done_c129", done, 1'b1);

        // Button held high: exactly one start, no pause
        do_reset();
        start_run(3'd0, 1'b0);
        step_to(50);  chk("held_led_c50", led, 16'h07FF);
        step_to(90);  chk("held_led_c90", led, LOOP ? 16'h01FF : 16'h0000);
                      chk("held_busy_c90", busy, LOOP);
        step_to(100); button = 1'b0;
        chk("held_done_count", done_seen, 1);

        // Asynchronous reset in the middle of DRAIN
        do_reset();
        start_run(3'd0, 1'b1);
        step_to(48);
        chk("abort_led_before", led, 16'h0FFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_led", led, 16'h0000);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        done_seen = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_seen, 0);
        chk("abort_idle", busy, 1'b0);

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) button = ~button;
            if ($urandom_range(0, 36) == 0) switch = 3'($urandom_range(0, 2));
            if (i == 2000) rst_n = 1'b0;
            if (i == 2002) rst_n = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
